// File: rtl/object_grid_writer.sv
// Kitchen object grid: one tile code per square, 1-cycle registered read port, and a
// valid/ready update queue whose entries only commit while vblank_in is high.
module object_grid_writer #(
    parameter int unsigned GRID_W     = 8,
    parameter int unsigned GRID_H     = 8,
    parameter int unsigned CODE_W     = 4,
    parameter int unsigned FIFO_DEPTH = 8,
    parameter int unsigned MAX_CODE   = 10,
    localparam int unsigned XW        = $clog2(GRID_W),
    localparam int unsigned YW        = $clog2(GRID_H),
    localparam int unsigned PW        = $clog2(FIFO_DEPTH) + 1
) (
    input  logic              clk_in,
    input  logic              rst_in_n,
    input  logic              upd_valid_in,
    output logic              upd_ready_out,
    input  logic [XW-1:0]     upd_x_in,
    input  logic [YW-1:0]     upd_y_in,
    input  logic [CODE_W-1:0] upd_code_in,
    input  logic              upd_clear_all_in,
    input  logic              vblank_in,
    input  logic [XW-1:0]     rd_x_in,
    input  logic [YW-1:0]     rd_y_in,
    output logic [CODE_W-1:0] rd_code_out,
    output logic [PW-1:0]     pending_out,
    output logic              busy_out,
    output logic [7:0]        err_count_out
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned NT = GRID_W * GRID_H;
    localparam int unsigned IW = $clog2(NT);
    localparam int unsigned DW = XW + YW + CODE_W;  // entry payload without the clear flag
    localparam int unsigned EW = DW + 1;

    typedef enum logic [1:0] {StIdle, StCommit, StClear} state_e;

    function automatic logic [IW-1:0] tile_idx(input logic [XW-1:0] x, input logic [YW-1:0] y);
        return IW'(32'(y) * GRID_W + 32'(x));
    endfunction

    function automatic logic xy_ok(input logic [XW-1:0] x, input logic [YW-1:0] y);
        return (32'(x) < GRID_W) && (32'(y) < GRID_H);
    endfunction

    // ---------------- update queue ----------------
    logic [EW-1:0] fifo_q [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [PW-1:0] count_q;
    logic          full, empty, push, pop;
    logic [EW-1:0] head;
    logic          head_clear;

    assign full       = (count_q == PW'(FIFO_DEPTH));
    assign empty      = (count_q == '0);
    assign push       = upd_valid_in && !full;
    assign head       = fifo_q[rd_ptr_q];
    assign head_clear = head[EW-1];

    always_ff @(posedge clk_in) begin
        if (push) begin
            fifo_q[wr_ptr_q] <= {upd_clear_all_in, upd_x_in, upd_y_in, upd_code_in};
        end
    end

    always_ff @(posedge clk_in or negedge rst_in_n) begin
        if (!rst_in_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            unique case ({push, pop})
                2'b10:   count_q <= count_q + PW'(1);
                2'b01:   count_q <= count_q - PW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    assign upd_ready_out = !full;
    assign pending_out   = count_q;

    // ---------------- FSM ----------------
    state_e          state_q, state_d;
    logic [DW-1:0]   cur_q, cur_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic [7:0]      err_q;
    logic [XW-1:0]   cur_x;
    logic [YW-1:0]   cur_y;
    logic [CODE_W-1:0] cur_code;
    logic            cur_legal;
    logic            tile_we, err_inc;
    logic [IW-1:0]   tile_wa;
    logic [CODE_W-1:0] tile_wd;

    assign cur_x     = cur_q[DW-1 -: XW];
    assign cur_y     = cur_q[YW+CODE_W-1 -: YW];
    assign cur_code  = cur_q[CODE_W-1:0];
    assign cur_legal = xy_ok(cur_x, cur_y) && (32'(cur_code) <= MAX_CODE);

    always_ff @(posedge clk_in or negedge rst_in_n) begin
        if (!rst_in_n) begin
            state_q <= StIdle;
            cur_q   <= '0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            cur_q   <= cur_d;
            idx_q   <= idx_d;
        end
    end

    // IDLE and COMMIT share the pop decision so commits run back-to-back.
    always_comb begin
        state_d = state_q;
        pop     = 1'b0;
        unique case (state_q)
            StIdle, StCommit: begin
                if (vblank_in && !empty) begin
                    pop     = 1'b1;
                    state_d = head_clear ? StClear : StCommit;
                end else begin
                    state_d = StIdle;
                end
            end
            StClear: begin
                if (vblank_in && idx_q == IW'(NT - 1)) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        cur_d = pop ? head[DW-1:0] : cur_q;
        idx_d = idx_q;
        if (pop && head_clear) begin
            idx_d = '0;
        end else if (state_q == StClear && vblank_in) begin
            idx_d = idx_q + IW'(1);
        end
    end

    always_comb begin
        tile_we = 1'b0;
        tile_wa = idx_q;
        tile_wd = '0;
        err_inc = 1'b0;
        unique case (state_q)
            StCommit: begin
                tile_wa = tile_idx(cur_x, cur_y);
                if (cur_legal) begin
                    tile_we = 1'b1;
                    tile_wd = cur_code;
                end else begin
                    err_inc = 1'b1;
                end
            end
            StClear: tile_we = vblank_in;
            default: ;
        endcase
    end

    assign busy_out = (state_q != StIdle);

    always_ff @(posedge clk_in or negedge rst_in_n) begin
        if (!rst_in_n) begin
            err_q <= '0;
        end else if (err_inc && err_q != 8'hFF) begin
            err_q <= err_q + 8'd1;
        end
    end

    assign err_count_out = err_q;

    // ---------------- tile storage and read port ----------------
    logic [CODE_W-1:0] tiles_q [NT];
    logic [CODE_W-1:0] rd_code_q;
    logic              rd_ok;
    logic [IW-1:0]     rd_idx;

    assign rd_ok  = xy_ok(rd_x_in, rd_y_in);
    assign rd_idx = tile_idx(rd_x_in, rd_y_in);

    always_ff @(posedge clk_in or negedge rst_in_n) begin
        if (!rst_in_n) begin
            for (int i = 0; i < int'(NT); i++) tiles_q[i] <= '0;
        end else if (tile_we) begin
            tiles_q[tile_wa] <= tile_wd;
        end
    end

    // Reads sample pre-write contents, so a same-cycle write returns the old code.
    always_ff @(posedge clk_in or negedge rst_in_n) begin
        if (!rst_in_n) begin
            rd_code_q <= '0;
        end else begin
            rd_code_q <= rd_ok ? tiles_q[rd_idx] : '0;
        end
    end

    assign rd_code_out = rd_code_q;

endmodule

// File: tb/tb_object_grid_writer.sv
// Directed bench for object_grid_writer: reads are scoreboarded through a queue and
// checked by a monitor one cycle later; status outputs are compared directly.
module tb_object_grid_writer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       upd_valid = 1'b0;
    logic       upd_ready;
    logic [2:0] upd_x = '0;
    logic [2:0] upd_y = '0;
    logic [3:0] upd_code = '0;
    logic       upd_clear = 1'b0;
    logic       vblank = 1'b0;
    logic [2:0] rd_x = '0;
    logic [2:0] rd_y = '0;
    logic [3:0] rd_code;
    logic [3:0] pending;
    logic       busy;
    logic [7:0] err_count;

    int n_tests = 0;
    int n_fail  = 0;

    int    exp_q[$];
    string name_q[$];
    logic  rd_req = 1'b0;
    logic  fire = 1'b0;

    always #5 clk = ~clk;

    object_grid_writer dut (
        .clk_in          (clk),
        .rst_in_n        (rst_n),
        .upd_valid_in    (upd_valid),
        .upd_ready_out   (upd_ready),
        .upd_x_in        (upd_x),
        .upd_y_in        (upd_y),
        .upd_code_in     (upd_code),
        .upd_clear_all_in(upd_clear),
        .vblank_in       (vblank),
        .rd_x_in         (rd_x),
        .rd_y_in         (rd_y),
        .rd_code_out     (rd_code),
        .pending_out     (pending),
        .busy_out        (busy),
        .err_count_out   (err_count)
    );

    // Read monitor: a read issued at an edge is checked on the following negedge.
    always @(posedge clk) fire <= rd_req;

    always @(negedge clk) begin
        if (fire) begin
            n_tests++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL rd_unexpected: got %0d, required no read in flight", rd_code);
            end else begin
                int    e;
                string nm;
                e  = exp_q.pop_front();
                nm = name_q.pop_front();
                if (rd_code !== 4'(e)) begin
                    n_fail++;
                    $display("FAIL %s: got %0d, required %0d", nm, rd_code, e);
                end
            end
        end
    end

    task automatic check(input string nm, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, required %0d", nm, act, exp);
        end
    endtask

    task automatic read_tile(input int x, input int y, input int exp, input string nm);
        rd_x   = 3'(x);
        rd_y   = 3'(y);
        rd_req = 1'b1;
        exp_q.push_back(exp);
        name_q.push_back(nm);
        @(posedge clk);
        #1 rd_req = 1'b0;
    endtask

    task automatic push(input int x, input int y, input int code, input logic clr);
        upd_valid = 1'b1;
        upd_x     = 3'(x);
        upd_y     = 3'(y);
        upd_code  = 4'(code);
        upd_clear = clr;
        @(posedge clk);
        #1 upd_valid = 1'b0;
        upd_clear = 1'b0;
    endtask

    task automatic wait_idle(input string nm);
        int n;
        n = 0;
        while ((pending != 0 || busy) && n < 300) begin
            @(posedge clk);
            #1 n++;
        end
        n_tests++;
        if (pending != 0 || busy) begin
            n_fail++;
            $display("FAIL %s_timeout: pending=%0d busy=%0d, required 0/0", nm, pending, busy);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        // 1: reset state, all tiles empty
        repeat (3) @(posedge clk);
        #1;
        check("rst_ready", upd_ready, 1);
        check("rst_pending", pending, 0);
        check("rst_busy", busy, 0);
        check("rst_err", err_count, 0);
        check("rst_rd", rd_code, 0);
        rst_n = 1'b1;
        for (int y = 0; y < 8; y++)
            for (int x = 0; x < 8; x++) read_tile(x, y, 0, "rst_tile");

        // 2: entry waits for vblank, then commits
        push(3, 5, 7, 1'b0);
        check("t2_pending1", pending, 1);
        read_tile(3, 5, 0, "t2_before_vblank");
        vblank = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        read_tile(3, 5, 7, "t2_committed");
        check("t2_pending0", pending, 0);

        // 3: fill queue, reject 9th, drain one per cycle in order
        vblank = 1'b0;
        for (int i = 1; i <= 8; i++) push(0, 0, i, 1'b0);
        check("t3_pending8", pending, 8);
        check("t3_ready0", upd_ready, 0);
        push(7, 7, 3, 1'b0);
        check("t3_9th_dropped", pending, 8);
        vblank = 1'b1;
        for (int k = 0; k < 10; k++) read_tile(0, 0, (k < 2) ? 0 : k - 1, "t3_order");
        check("t3_drained", pending, 0);
        read_tile(7, 7, 0, "t3_9th_tile");

        // 4: illegal code counted, legal one applied
        vblank = 1'b0;
        push(1, 1, 12, 1'b0);
        push(1, 1, 4, 1'b0);
        vblank = 1'b1;
        wait_idle("t4");
        check("t4_err", err_count, 1);
        read_tile(1, 1, 4, "t4_tile11");
        read_tile(0, 0, 8, "t4_tile00");
        read_tile(3, 5, 7, "t4_tile35");
        read_tile(1, 0, 0, "t4_tile10");

        // 5: fill grid, then clear_all takes 64 vblank cycles
        for (int y = 0; y < 8; y++)
            for (int x = 0; x < 8; x++) push(x, y, (x + y) % 10 + 1, 1'b0);
        wait_idle("t5_fill");
        read_tile(2, 3, 6, "t5_fill23");
        read_tile(7, 7, 5, "t5_fill77");
        read_tile(0, 0, 1, "t5_fill00");
        vblank = 1'b0;
        push(0, 0, 0, 1'b1);
        check("t5_clear_pending", pending, 1);
        vblank = 1'b1;
        repeat (21) @(posedge clk);
        #1 check("t5_busy_mid", busy, 1);
        repeat (44) @(posedge clk);
        #1 check("t5_busy_done", busy, 0);
        for (int y = 0; y < 8; y++)
            for (int x = 0; x < 8; x++) read_tile(x, y, 0, "t5_cleared");

        // 6: read-during-write returns old value; reset mid-CLEAR
        vblank = 1'b0;
        push(2, 2, 4, 1'b0);
        vblank = 1'b1;
        wait_idle("t6_setup");
        vblank = 1'b0;
        push(2, 2, 9, 1'b0);
        vblank = 1'b1;
        read_tile(2, 2, 4, "t6_pop_cycle");
        read_tile(2, 2, 4, "t6_same_cycle_old");
        read_tile(2, 2, 9, "t6_next_new");
        vblank = 1'b0;
        push(0, 0, 0, 1'b1);
        push(4, 4, 7, 1'b0);
        vblank = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        check("t6_busy_clear", busy, 1);
        check("t6_pending_clear", pending, 1);
        rst_n = 1'b0;
        #2;
        check("t6_rst_pending", pending, 0);
        check("t6_rst_busy", busy, 0);
        check("t6_rst_ready", upd_ready, 1);
        check("t6_rst_err", err_count, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        read_tile(2, 2, 0, "t6_rst_tile22");
        read_tile(4, 4, 0, "t6_rst_tile44");
        read_tile(7, 7, 0, "t6_rst_tile77");

        @(posedge clk);
        #1;
        check("sb_empty", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
